// File: rtl/axi_lite_reg_pkg.sv
// rtl/axi_lite_reg_pkg.sv - shared FSM encoding, port-select width and response constants
package axi_lite_reg_pkg;

    localparam int SEL_WIDTH = 3;

    typedef logic [SEL_WIDTH-1:0] sel_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic RESP_VALID   = 1'b0;
    localparam logic RESP_INVALID = 1'b1;

endpackage

// File: rtl/axi_lite_reg_router_if.sv
// rtl/axi_lite_reg_router_if.sv - upstream register bus plus downstream per-port bank signals
interface axi_lite_reg_router_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4
);
    logic [ADDR_WIDTH-1:0]           i_reg_address;
    logic                            i_reg_in_rdy;
    logic [DATA_WIDTH-1:0]           i_reg_in_data;
    logic                            o_reg_in_ack;
    logic                            i_reg_out_req;
    logic                            o_reg_out_rdy;
    logic [DATA_WIDTH-1:0]           o_reg_out_data;
    logic                            o_reg_invalid_addr;
    logic [ADDR_WIDTH-1:0]           o_port_address;
    logic [DATA_WIDTH-1:0]           o_port_in_data;
    logic [NUM_PORTS-1:0]            o_port_in_rdy;
    logic [NUM_PORTS-1:0]            i_port_in_ack;
    logic [NUM_PORTS-1:0]            o_port_out_req;
    logic [NUM_PORTS-1:0]            i_port_out_rdy;
    logic [NUM_PORTS*DATA_WIDTH-1:0] i_port_out_data;
    logic [NUM_PORTS-1:0]            i_port_invalid_addr;

    modport slave (
        input  i_reg_address, i_reg_in_rdy, i_reg_in_data, i_reg_out_req,
        input  i_port_in_ack, i_port_out_rdy, i_port_out_data, i_port_invalid_addr,
        output o_reg_in_ack, o_reg_out_rdy, o_reg_out_data, o_reg_invalid_addr,
        output o_port_address, o_port_in_data, o_port_in_rdy, o_port_out_req
    );

    modport master (
        output i_reg_address, i_reg_in_rdy, i_reg_in_data, i_reg_out_req,
        output i_port_in_ack, i_port_out_rdy, i_port_out_data, i_port_invalid_addr,
        input  o_reg_in_ack, o_reg_out_rdy, o_reg_out_data, o_reg_invalid_addr,
        input  o_port_address, o_port_in_data, o_port_in_rdy, o_port_out_req
    );
endinterface

// File: rtl/reg_timeout_timer.sv
// rtl/reg_timeout_timer.sv - downstream reply watchdog; expired flags the last allowed request cycle
module reg_timeout_timer #(
    parameter int CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(CYCLES);
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // A count of one means this is the CYCLES-th request cycle; a reply now still wins.
    assign expired = enable && (count == CNT_W'(1));

endmodule

// File: rtl/axi_lite_reg_router.sv
// rtl/axi_lite_reg_router.sv - routes one upstream register access at a time to a downstream bank
module axi_lite_reg_router
    import axi_lite_reg_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PORTS      = 4,
    parameter int PORT_SEL_LSB   = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_rst,
    axi_lite_reg_router_if.slave  bus
);
    state_t                state;
    logic                  is_write;
    logic [NUM_PORTS-1:0]  sel_mask;
    logic                  resp_invalid;
    logic [DATA_WIDTH-1:0] resp_data;

    sel_t                  req_sel;
    logic                  req_valid;
    logic [NUM_PORTS-1:0]  req_mask;
    logic                  timer_load;
    logic                  timer_enable;
    logic                  timer_expired;
    logic                  port_ack_hit;
    logic                  port_rdy_hit;
    logic                  port_invalid;
    logic [DATA_WIDTH-1:0] port_data;

    always_comb begin
        req_sel   = bus.i_reg_address[PORT_SEL_LSB +: SEL_WIDTH];
        req_valid = ({1'b0, req_sel} < (SEL_WIDTH + 1)'(NUM_PORTS));
        req_mask  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            req_mask[k] = (req_sel == SEL_WIDTH'(k));
        end
    end

    // Only the latched port's replies are visible; everything else is masked away.
    always_comb begin
        port_ack_hit = |(bus.i_port_in_ack & sel_mask);
        port_rdy_hit = |(bus.i_port_out_rdy & sel_mask);
        port_invalid = |(bus.i_port_invalid_addr & sel_mask);
        port_data    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (sel_mask[k]) begin
                port_data = bus.i_port_out_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign timer_load   = (state == ST_IDLE) && (bus.i_reg_in_rdy || bus.i_reg_out_req) && req_valid;
    assign timer_enable = (state == ST_WRITE) || (state == ST_READ);

    reg_timeout_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (i_axi_clk),
        .rst     (i_axi_rst),
        .load    (timer_load),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            state                  <= ST_IDLE;
            is_write               <= 1'b0;
            sel_mask               <= '0;
            resp_invalid           <= 1'b0;
            resp_data              <= '0;
            bus.o_reg_in_ack       <= 1'b0;
            bus.o_reg_out_rdy      <= 1'b0;
            bus.o_reg_out_data     <= '0;
            bus.o_reg_invalid_addr <= 1'b0;
            bus.o_port_address     <= '0;
            bus.o_port_in_data     <= '0;
            bus.o_port_in_rdy      <= '0;
            bus.o_port_out_req     <= '0;
        end else begin
            bus.o_reg_in_ack       <= 1'b0;
            bus.o_reg_out_rdy      <= 1'b0;
            bus.o_reg_invalid_addr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_reg_in_rdy || bus.i_reg_out_req) begin
                        is_write           <= bus.i_reg_in_rdy;
                        bus.o_port_address <= bus.i_reg_address;
                        if (bus.i_reg_in_rdy) begin
                            bus.o_port_in_data <= bus.i_reg_in_data;
                        end
                        sel_mask     <= req_mask;
                        resp_data    <= '0;
                        resp_invalid <= req_valid ? RESP_VALID : RESP_INVALID;
                        if (!req_valid) begin
                            state <= ST_RESP;
                        end else if (bus.i_reg_in_rdy) begin
                            bus.o_port_in_rdy <= req_mask;
                            state             <= ST_WRITE;
                        end else begin
                            bus.o_port_out_req <= req_mask;
                            state              <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (port_ack_hit) begin
                        bus.o_port_in_rdy <= '0;
                        resp_invalid      <= port_invalid;
                        state             <= ST_RESP;
                    end else if (timer_expired) begin
                        bus.o_port_in_rdy <= '0;
                        resp_invalid      <= RESP_INVALID;
                        state             <= ST_RESP;
                    end
                end
                ST_READ: begin
                    if (port_rdy_hit) begin
                        bus.o_port_out_req <= '0;
                        resp_invalid       <= port_invalid;
                        resp_data          <= port_data;
                        state              <= ST_RESP;
                    end else if (timer_expired) begin
                        bus.o_port_out_req <= '0;
                        resp_invalid       <= RESP_INVALID;
                        resp_data          <= '0;
                        state              <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (is_write) begin
                        bus.o_reg_in_ack <= 1'b1;
                    end else begin
                        bus.o_reg_out_rdy  <= 1'b1;
                        bus.o_reg_out_data <= resp_data;
                    end
                    bus.o_reg_invalid_addr <= resp_invalid;
                    state                  <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Wait out the held request level so it cannot relaunch.
                    if (is_write ? !bus.i_reg_in_rdy : !bus.i_reg_out_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_router.sv
// tb/tb_axi_lite_reg_router.sv - self-checking bench for axi_lite_reg_router
module tb_axi_lite_reg_router;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int NP    = 4;
    localparam int LSB   = 8;
    localparam int T     = 16;
    localparam int NEVER = 1000;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] pdata;
        bit          pinv;
        bit          spur;
        int          exp_lat;
        bit          exp_inv;
        logic [31:0] exp_data;
        int          exp_req;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_reg_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

    axi_lite_reg_router #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_PORTS      (NP),
        .PORT_SEL_LSB   (LSB),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_axi_clk (clk),
        .i_axi_rst (rst),
        .bus       (bus.slave)
    );

    int          checks  = 0;
    int          errors  = 0;
    logic [31:0] last_rd = '0;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, input logic [31:0] pdata, input bit pinv, input bit spur,
                                input int lat, input bit inv, input logic [31:0] data, input int req);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.delay = delay; v.pdata = pdata;
        v.pinv = pinv; v.spur = spur; v.exp_lat = lat; v.exp_inv = inv; v.exp_data = data; v.exp_req = req;
        return v;
    endfunction

    // Reference: request sample to pulse is 2 cycles plus the number of request cycles used.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int p = int'(v.addr[LSB +: 3]);
        if (p >= NP) begin
            r.exp_lat = 2; r.exp_inv = 1'b1; r.exp_data = '0; r.exp_req = 0;
        end else if (v.delay < T) begin
            r.exp_lat = v.delay + 3; r.exp_inv = v.pinv; r.exp_data = v.wr ? 32'h0 : v.pdata; r.exp_req = v.delay + 1;
        end else begin
            r.exp_lat = T + 2; r.exp_inv = 1'b1; r.exp_data = '0; r.exp_req = T;
        end
        return r;
    endfunction

    task automatic clear_ports();
        bus.i_port_in_ack       = '0;
        bus.i_port_out_rdy      = '0;
        bus.i_port_out_data     = '0;
        bus.i_port_invalid_addr = '0;
    endtask

    task automatic serve(input vec_t v, input int extra, input string name);
        int p, q, n, reqcnt, lat, hold;
        bit got, bad_route, bad_hold, dir_ok, inv_seen;
        logic [DW-1:0] data_seen;
        logic [NP-1:0] emask, act, oth;
        p = int'(v.addr[LSB +: 3]);
        q = (p + NP - 1) % NP;
        emask = '0;
        if (p < NP) emask[p] = 1'b1;
        n = 0; reqcnt = 0; got = 1'b0; bad_route = 1'b0; lat = 0;
        dir_ok = 1'b0; inv_seen = 1'b0; data_seen = '0;
        while (!got && n < 80) begin
            @(negedge clk);
            n++;
            clear_ports();
            act = v.wr ? bus.o_port_in_rdy : bus.o_port_out_req;
            oth = v.wr ? bus.o_port_out_req : bus.o_port_in_rdy;
            if (act != '0 || oth != '0) begin
                reqcnt++;
                if (act !== emask || oth !== '0 || bus.o_port_address !== v.addr ||
                    (v.wr && bus.o_port_in_data !== v.wdata)) bad_route = 1'b1;
                if (reqcnt == v.delay + 1) begin
                    if (v.wr) bus.i_port_in_ack[p] = 1'b1;
                    else begin
                        bus.i_port_out_rdy[p] = 1'b1;
                        bus.i_port_out_data[p*DW +: DW] = v.pdata;
                    end
                    bus.i_port_invalid_addr[p] = v.pinv;
                end else if (v.spur && reqcnt == 1) begin
                    if (v.wr) begin
                        bus.i_port_in_ack[q]  = 1'b1;
                        bus.i_port_out_rdy[p] = 1'b1;
                    end else begin
                        bus.i_port_out_rdy[q] = 1'b1;
                        bus.i_port_out_data[q*DW +: DW] = ~v.pdata;
                        bus.i_port_in_ack[p]  = 1'b1;
                    end
                    bus.i_port_invalid_addr = '1;
                end
            end
            if (bus.o_reg_in_ack || bus.o_reg_out_rdy) begin
                got       = 1'b1;
                lat       = n;
                dir_ok    = v.wr ? (bus.o_reg_in_ack && !bus.o_reg_out_rdy) : (bus.o_reg_out_rdy && !bus.o_reg_in_ack);
                inv_seen  = bus.o_reg_invalid_addr;
                data_seen = bus.o_reg_out_data;
            end
        end
        chk({name, "_pulse"}, 128'(got), 128'(1));
        if (got) begin
            chk({name, "_lat"}, 128'(lat), 128'(v.exp_lat + extra));
            chk({name, "_dir"}, 128'(dir_ok), 128'(1));
            chk({name, "_inv"}, 128'(inv_seen), 128'(v.exp_inv));
            chk({name, "_data"}, 128'(data_seen), 128'(v.wr ? last_rd : v.exp_data));
            chk({name, "_reqcyc"}, 128'(reqcnt), 128'(v.exp_req));
            chk({name, "_route"}, 128'(bad_route), 128'(0));
        end
        if (!v.wr) last_rd = v.exp_data;
        bad_hold = 1'b0;
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            clear_ports();
            if (bus.o_reg_in_ack || bus.o_reg_out_rdy || bus.o_port_in_rdy != '0 || bus.o_port_out_req != '0)
                bad_hold = 1'b1;
        end
        chk({name, "_hold"}, 128'(bad_hold), 128'(0));
        if (v.wr) bus.i_reg_in_rdy = 1'b0;
        else bus.i_reg_out_req = 1'b0;
    endtask

    task automatic run(input vec_t v, input string name);
        @(negedge clk);
        bus.i_reg_address = v.addr;
        bus.i_reg_in_data = v.wdata;
        if (v.wr) bus.i_reg_in_rdy = 1'b1;
        else bus.i_reg_out_req = 1'b1;
        serve(v, 0, name);
    endtask

    initial begin
        vec_t v;
        bit bad;
        bus.i_reg_address = '0;
        bus.i_reg_in_rdy  = 1'b0;
        bus.i_reg_in_data = '0;
        bus.i_reg_out_req = 1'b0;
        clear_ports();

        vecs[0] = mk(1, 32'h0000_0104, 32'h1234_5678, 2,     32'h0,         0, 0, 5,  0, 32'h0,         3);
        vecs[1] = mk(0, 32'h0000_0300, 32'h0,         0,     32'hCAFE_F00D, 1, 0, 3,  1, 32'hCAFE_F00D, 1);
        vecs[2] = mk(0, 32'h0000_0500, 32'h0,         0,     32'h1,         0, 0, 2,  1, 32'h0,         0);
        vecs[3] = mk(1, 32'h0000_0200, 32'h0000_A5A5, NEVER, 32'h0,         0, 0, 18, 1, 32'h0,         16);
        vecs[4] = mk(0, 32'h0000_00FC, 32'h0,         15,    32'h0BAD_BEEF, 0, 0, 18, 0, 32'h0BAD_BEEF, 16);
        vecs[5] = mk(0, 32'h0000_01F0, 32'h0,         16,    32'h1111_1111, 0, 0, 18, 1, 32'h0,         16);
        vecs[6] = mk(1, 32'h0000_03FC, 32'h7777_0000, 0,     32'h0,         1, 0, 3,  1, 32'h0,         1);
        vecs[7] = mk(1, 32'h0000_0400, 32'h0000_4444, 0,     32'h0,         0, 0, 2,  1, 32'h0,         0);
        vecs[8] = mk(0, 32'hFFFF_F204, 32'h0,         1,     32'h5555_AAAA, 0, 1, 4,  0, 32'h5555_AAAA, 2);
        vecs[9] = mk(1, 32'h0000_0704, 32'h0000_0707, 0,     32'h0,         0, 0, 2,  1, 32'h0,         0);

        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({bus.o_reg_in_ack, bus.o_reg_out_rdy, bus.o_reg_out_data, bus.o_reg_invalid_addr,
                                   bus.o_port_address, bus.o_port_in_data, bus.o_port_in_rdy, bus.o_port_out_req}), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run(vecs[i], $sformatf("vec%0d", i));

        // Write and read raised together: write first, read after drain; port-0 spurious ack during port-1 read.
        @(negedge clk);
        bus.i_reg_address = 32'h0000_0100;
        bus.i_reg_in_data = 32'hDEAD_0001;
        bus.i_reg_in_rdy  = 1'b1;
        bus.i_reg_out_req = 1'b1;
        serve(model(mk(1, 32'h0000_0100, 32'hDEAD_0001, 1, 32'h0, 0, 0, 0, 0, 32'h0, 0)), 0, "both_wr");
        serve(model(mk(0, 32'h0000_0100, 32'h0, 2, 32'h0F0F_1234, 0, 1, 0, 0, 32'h0, 0)), 1, "both_rd");

        // Port 2 never acks; its late ack afterwards must be ignored.
        run(model(mk(1, 32'h0000_0208, 32'h0000_2222, NEVER, 32'h0, 0, 0, 0, 0, 32'h0, 0)), "tmo_wr");
        @(negedge clk);
        bus.i_port_in_ack[2]       = 1'b1;
        bus.i_port_invalid_addr[2] = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            clear_ports();
            if (bus.o_reg_in_ack || bus.o_reg_out_rdy || bus.o_port_in_rdy != '0) bad = 1'b1;
        end
        chk("late_ack_ignored", 128'(bad), 128'(0));

        // Reset while a read to port 3 is pending.
        @(negedge clk);
        bus.i_reg_address = 32'h0000_0300;
        bus.i_reg_out_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_req", 128'(bus.o_port_out_req), 128'(4'b1000));
        rst = 1'b1;
        #1;
        chk("midreset_outputs", 128'({bus.o_reg_in_ack, bus.o_reg_out_rdy, bus.o_reg_out_data, bus.o_reg_invalid_addr,
                                      bus.o_port_address, bus.o_port_in_data, bus.o_port_in_rdy, bus.o_port_out_req}), 128'(0));
        last_rd = '0;
        bus.i_reg_out_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(model(mk(0, 32'h0000_0300, 32'h0, 1, 32'h600D_F00D, 0, 0, 0, 0, 32'h0, 0)), "post_reset_rd");

        for (int i = 0; i < 40; i++) begin
            int r;
            v.wr = 1'($urandom_range(0, 1));
            v.addr = $urandom;
            v.addr[LSB +: 3] = 3'($urandom_range(0, 7));
            v.wdata = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7) v.delay = $urandom_range(0, 4);
            else if (r == 7) v.delay = T - 1;
            else if (r == 8) v.delay = T;
            else v.delay = NEVER;
            v.pdata = $urandom;
            v.pinv = 1'($urandom_range(0, 1));
            v.spur = (v.delay >= 1) && ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(model(v), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_reg_router.md
AXI_LITE_REG_ROUTER -- requirements
Module: axi_lite_reg_router

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, register address width.
REQ-002 DATA_WIDTH, default 32, register data width.
REQ-003 NUM_PORTS, default 4, range 1..8, number of downstream register banks.
REQ-004 PORT_SEL_LSB, default 8, LSB of the 3-bit port-select field, address[PORT_SEL_LSB+2:PORT_SEL_LSB].
REQ-005 TIMEOUT_CYCLES, default 256, minimum 2, cycles allowed for a downstream reply.
REQ-006 Ports SHALL be as follows. One clock; reset is asynchronous and active-high.
- i_axi_clk  in  1  clock.
- i_axi_rst  in  1  asynchronous active-high reset.
- i_reg_address  in  ADDR_WIDTH  upstream register address.
- i_reg_in_rdy  in  1  upstream write request, level, held until ack.
- i_reg_in_data  in  DATA_WIDTH  upstream write data.
- o_reg_in_ack  out  1  write complete, one-cycle pulse.
- i_reg_out_req  in  1  upstream read request, level, held until rdy.
- o_reg_out_rdy  out  1  read data valid, one-cycle pulse.
- o_reg_out_data  out  DATA_WIDTH  read data.
- o_reg_invalid_addr  out  1  error flag, valid with ack/rdy pulse.
- o_port_address  out  ADDR_WIDTH  latched address, broadcast to all ports.
- o_port_in_data  out  DATA_WIDTH  latched write data, broadcast.
- o_port_in_rdy  out  NUM_PORTS  per-port write request, one-hot.
- i_port_in_ack  in  NUM_PORTS  per-port write ack pulse.
- o_port_out_req  out  NUM_PORTS  per-port read request, one-hot.
- i_port_out_rdy  in  NUM_PORTS  per-port read-ready pulse.
- i_port_out_data  in  NUM_PORTS*DATA_WIDTH  read data, port k at slice k.
- i_port_invalid_addr  in  NUM_PORTS  per-port error flag, sampled with that port's ack/rdy.

Function
REQ-007 The FSM SHALL have states IDLE, WRITE, READ, RESP and DRAIN; all outputs are registered.
REQ-008 In IDLE with i_reg_in_rdy=1, the block SHALL latch address and data, compute sel, and enter WRITE; write wins when i_reg_in_rdy and i_reg_out_req are both high.
REQ-009 In IDLE with only i_reg_out_req=1, the block SHALL latch the address and enter READ.
REQ-010 If sel>=NUM_PORTS, the block SHALL go directly to RESP with invalid=1, read data 0, and no downstream request.
REQ-011 In WRITE/READ, the block SHALL hold o_port_in_rdy[sel]/o_port_out_req[sel] high from the cycle after latch until the cycle after the matching ack/rdy, then enter RESP.
REQ-012 Downstream ack/rdy from any port other than sel, or of the wrong direction, SHALL be ignored.
REQ-013 Read data and the invalid flag SHALL be captured from port sel in the ack/rdy cycle.
REQ-014 A timeout counter SHALL load TIMEOUT_CYCLES on launch and decrement each cycle in WRITE/READ; at zero the block SHALL drop the request and enter RESP with invalid=1 and read data 0.
REQ-015 RESP SHALL last exactly one cycle, pulsing o_reg_in_ack or o_reg_out_rdy with o_reg_invalid_addr, then enter DRAIN.
REQ-016 DRAIN SHALL wait for the served upstream request to deassert, then return to IDLE, so a held level never launches twice.
REQ-017 Latency for a valid port that acks in the first request cycle SHALL be 3 cycles from the request sample to the upstream pulse.
REQ-018 o_reg_out_data SHALL hold its last value outside RESP.

Reset
REQ-019 Asserting i_axi_rst at any time, including mid-transaction, SHALL immediately force IDLE and drive every output and internal register to 0; in-flight transactions are abandoned without an upstream pulse.

Structure
REQ-020 The state encoding, the 3-bit port-select width and the response constants SHALL live in a shared package, axi_lite_reg_pkg.
REQ-021 The timeout counter SHALL be one sub-module, reg_timeout_timer, with load, enable and expired ports.

Verification
REQ-022 Write 0x12345678 to 0x104 (port 1), port acks 2 cycles later -> o_port_in_rdy=4'b0010, o_port_in_data=0x12345678, one o_reg_in_ack pulse, invalid=0.
REQ-023 Read 0x300 (port 3), port returns 0xCAFEF00D with invalid=1 -> o_reg_out_data=0xCAFEF00D, o_reg_invalid_addr=1 with the o_reg_out_rdy pulse.
REQ-024 Read 0x500 with NUM_PORTS=4 -> no downstream request, o_reg_out_rdy pulse with data 0 and invalid=1.
REQ-025 Write to port 2, which never acks, TIMEOUT_CYCLES=16 -> o_reg_in_ack with invalid=1 exactly 16 cycles after launch; a later port-2 ack is ignored.
REQ-026 i_reg_in_rdy and i_reg_out_req rise together -> write served first, the read follows after DRAIN; a spurious port-0 ack during a port-1 read has no effect.
REQ-027 Assert reset while in READ -> all outputs 0 in the same cycle; after release, a new read completes normally.
